prng_burst_ctrl: RTL and testbench
==================================

// Module: prng_burst_ctrl
// PURPOSE
//  Parametrised Galois-LFSR random-number generator with integrated control FSM.
//  Free-runs the LFSR while idle-mixing. On a request, it gathers OUT_W fresh bits per
//  word and delivers a burst of 1..2^CNT_W words over a valid/ready handshake.
//  Supports runtime seed loading. Sits between the PRNG datapath and its consumer.
// PARAMETERS
//  LFSR_W        16        LFSR width (>=3)
//  OUT_W         8         bits per output word (>=2)
//  TAPS          16'hB400  Galois feedback mask, LFSR_W bits, applied on right shift
//  SEED_DEFAULT  16'hACE1  reset seed; also substituted for an all-zero seed_in (must be nonzero)
//  CNT_W         4         width of burst_len
// PORTS
//  clk         in   1       clock, rising edge
//  rstn        in   1       asynchronous active-low reset
//  seed_load   in   1       load seed_in into LFSR this cycle (highest priority)
//  seed_in     in   LFSR_W  new seed
//  get_random  in   1       burst request, sampled in IDLE/SHIFT only
//  burst_len   in   CNT_W   words in burst minus 1, latched with get_random
//  rnd_ready   in   1       consumer accepts rnd_data when rnd_valid=1
//  rnd_data    out  OUT_W   random word
//  rnd_valid   out  1       rnd_data valid
//  busy        out  1       1 in GATHER or PRESENT
//  done        out  1       one-cycle pulse: last word of burst accepted
//  state       out  2       IDLE=00, SHIFT=01, GATHER=10, PRESENT=11
// BEHAVIOUR
//  Reset: state=IDLE, lfsr=SEED_DEFAULT, rnd_data=0, rnd_valid=0, done=0, busy=0, counters=0.
//  LFSR step: nxt = lfsr[0] ? (lfsr>>1)^TAPS : lfsr>>1. The output bit is lfsr[0] before the step.
//  The LFSR holds in IDLE and steps once per clock in SHIFT, GATHER and PRESENT.
//  seed_load, any state: lfsr <= (seed_in==0 ? SEED_DEFAULT : seed_in); state->SHIFT.
//   Any burst in flight is aborted: rnd_valid=0, no done pulse. A simultaneous get_random is dropped.
//  IDLE: get_random -> GATHER; else -> SHIFT.
//  SHIFT: get_random -> GATHER; else stay.
//  On entry to GATHER from IDLE/SHIFT: word_cnt<=burst_len, bit_cnt<=0.
//  GATHER: sh <= {sh[OUT_W-2:0], lfsr[0]}; bit_cnt++.
//   At bit_cnt==OUT_W-1: rnd_data <= {sh[OUT_W-2:0], lfsr[0]}, rnd_valid<=1, ->PRESENT.
//   The first gathered bit ends up as the MSB.
//  Latency: rnd_valid rises OUT_W clocks after the edge that samples get_random.
//  PRESENT: rnd_data is held stable while rnd_valid & !rnd_ready.
//   On rnd_valid & rnd_ready:
//    word_cnt==0: done<=1 for one cycle, rnd_valid<=0, ->SHIFT.
//    else: word_cnt--, bit_cnt<=0, rnd_valid<=0, ->GATHER.
//   Words are therefore never back-to-back; there is a minimum OUT_W-cycle gap.
//  get_random is ignored while busy (not queued).
//  burst_len is read only at request acceptance; later changes have no effect.
//  Unused encodings: none (2-bit state fully used). On glitch, default arm ->IDLE.
//  rnd_data keeps the last word after a burst; only reset clears it.
// TESTING
//  1 Reset, get_random=1, burst_len=0 at first edge -> valid after 8 clks, rnd_data=8'h87,
//    done pulse on accept, lfsr=16'hC2C4 at accept edge+... (check lfsr=16'hC2C4 at PRESENT entry).
//  2 Idle free-run from reset, no request: state IDLE->SHIFT; lfsr sequence ACE1,ACE1(IDLE hold),E270,7138,389C.
//  3 burst_len=3, rnd_ready held 0 for 5 clks on word 1 -> rnd_data stable; exactly 4 accepts,
//    a single done on the 4th, state=SHIFT afterwards.
//  4 seed_load with seed_in=0 during GATHER -> lfsr=ACE1, state=SHIFT, rnd_valid=0, done=0;
//    seed_in=16'h1234 -> lfsr=1234.
//  5 get_random pulses while busy -> ignored: the accepted-word count equals the original burst_len+1.
//  6 rstn low mid-PRESENT (async, off-edge) -> all outputs at reset values immediately; then resume test 1.

Source files
------------

// File: rtl/prng_burst_ctrl.sv
// Galois-LFSR random word generator with burst control FSM.
// Ports: clk/rstn, seed_load/seed_in, get_random/burst_len, rnd_* handshake, busy/done/state.
module prng_burst_ctrl #(
  parameter int                LFSR_W       = 16,
  parameter int                OUT_W        = 8,
  parameter logic [LFSR_W-1:0] TAPS         = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED_DEFAULT = 16'hACE1,
  parameter int                CNT_W        = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic              get_random,
  input  logic [CNT_W-1:0]  burst_len,
  input  logic              rnd_ready,
  output logic [OUT_W-1:0]  rnd_data,
  output logic              rnd_valid,
  output logic              busy,
  output logic              done,
  output logic [1:0]        state
);

  localparam int BIT_W = (OUT_W > 2) ? $clog2(OUT_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(OUT_W - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_SHIFT   = 2'b01,
    S_GATHER  = 2'b10,
    S_PRESENT = 2'b11
  } state_t;

  state_t            r_state;
  logic [LFSR_W-1:0] r_lfsr;
  logic [OUT_W-2:0]  r_sh;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic [CNT_W-1:0]  r_word_cnt;
  logic [OUT_W-1:0]  r_data;
  logic              r_valid;
  logic              r_done;

  state_t            w_state_nxt;
  logic [LFSR_W-1:0] w_lfsr_nxt;
  logic [OUT_W-2:0]  w_sh_nxt;
  logic [BIT_W-1:0]  w_bit_nxt;
  logic [CNT_W-1:0]  w_word_nxt;
  logic [OUT_W-1:0]  w_data_nxt;
  logic              w_valid_nxt;
  logic              w_done_nxt;

  logic [LFSR_W-1:0] w_step;
  logic [LFSR_W-1:0] w_seed;
  logic [OUT_W-1:0]  w_sh_cat;

  assign w_step   = r_lfsr[0] ? ((r_lfsr >> 1) ^ TAPS)
                              : (r_lfsr >> 1);
  // An all-zero seed would lock the LFSR; substitute the default.
  assign w_seed   = (seed_in == '0) ? SEED_DEFAULT : seed_in;
  // Oldest gathered bit ends up in the MSB.
  assign w_sh_cat = {r_sh, r_lfsr[0]};

  always_comb begin
    w_state_nxt = r_state;
    w_lfsr_nxt  = r_lfsr;
    w_sh_nxt    = r_sh;
    w_bit_nxt   = r_bit_cnt;
    w_word_nxt  = r_word_cnt;
    w_data_nxt  = r_data;
    w_valid_nxt = r_valid;
    w_done_nxt  = 1'b0;
    if (seed_load) begin
      w_lfsr_nxt  = w_seed;
      w_valid_nxt = 1'b0;
      w_state_nxt = S_SHIFT;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (get_random) begin
            w_state_nxt = S_GATHER;
            w_word_nxt  = burst_len;
            w_bit_nxt   = '0;
          end else begin
            w_state_nxt = S_SHIFT;
          end
        end
        S_SHIFT: begin
          w_lfsr_nxt = w_step;
          if (get_random) begin
            w_state_nxt = S_GATHER;
            w_word_nxt  = burst_len;
            w_bit_nxt   = '0;
          end
        end
        S_GATHER: begin
          w_lfsr_nxt = w_step;
          w_sh_nxt   = w_sh_cat[OUT_W-2:0];
          if (r_bit_cnt == LAST_BIT) begin
            w_bit_nxt   = '0;
            w_data_nxt  = w_sh_cat;
            w_valid_nxt = 1'b1;
            w_state_nxt = S_PRESENT;
          end else begin
            w_bit_nxt = r_bit_cnt + BIT_W'(1);
          end
        end
        S_PRESENT: begin
          w_lfsr_nxt = w_step;
          if (r_valid && rnd_ready) begin
            w_valid_nxt = 1'b0;
            if (r_word_cnt == '0) begin
              w_done_nxt  = 1'b1;
              w_state_nxt = S_SHIFT;
            end else begin
              w_word_nxt  = r_word_cnt - CNT_W'(1);
              w_bit_nxt   = '0;
              w_state_nxt = S_GATHER;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_lfsr     <= SEED_DEFAULT;
      r_sh       <= '0;
      r_bit_cnt  <= '0;
      r_word_cnt <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_lfsr     <= w_lfsr_nxt;
      r_sh       <= w_sh_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_word_cnt <= w_word_nxt;
      r_data     <= w_data_nxt;
      r_valid    <= w_valid_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign rnd_data  = r_data;
  assign rnd_valid = r_valid;
  assign done      = r_done;
  assign state     = r_state;
  assign busy      = (r_state == S_GATHER) ||
                     (r_state == S_PRESENT);

endmodule

// File: tb/tb_prng_burst_ctrl.sv
// Randomised self-checking bench for prng_burst_ctrl.
// Reference: LFSR bit stream model plus handshake timing rules.
module tb_prng_burst_ctrl;

  localparam int OW = 8;
  localparam int CW = 4;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [15:0] TAPS = 16'hB400;

  logic        clk = 1'b0;
  logic        rstn;
  logic        seed_load;
  logic [15:0] seed_in;
  logic        get_random;
  logic [3:0]  burst_len;
  logic        rnd_ready;
  logic [7:0]  rnd_data;
  logic        rnd_valid;
  logic        busy;
  logic        done;
  logic [1:0]  state;

  int n_cmp = 0;
  int n_bad = 0;

  bit          hist[$];
  logic [15:0] m_lfsr;
  logic        m_fresh;
  logic [7:0]  last_word;
  logic [15:0] lfsr_pres;

  prng_burst_ctrl dut (
    .clk        (clk),
    .rstn       (rstn),
    .seed_load  (seed_load),
    .seed_in    (seed_in),
    .get_random (get_random),
    .burst_len  (burst_len),
    .rnd_ready  (rnd_ready),
    .rnd_data   (rnd_data),
    .rnd_valid  (rnd_valid),
    .busy       (busy),
    .done       (done),
    .state      (state)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] f_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
  endfunction

  // Word gathered from the OUT_W edges following edge s, first bit MSB.
  function automatic logic [7:0] f_word(input int s);
    logic [7:0] w = '0;
    for (int i = 1; i <= OW; i++) w = {w[6:0], hist[s+i]};
    return w;
  endfunction

  // LFSR holds only on the first edge after reset (IDLE), else steps.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_lfsr  <= SEED;
      m_fresh <= 1'b1;
    end else begin
      hist.push_back(m_lfsr[0]);
      if (seed_load) begin
        m_lfsr  <= (seed_in == 16'h0) ? SEED : seed_in;
        m_fresh <= 1'b0;
      end else if (m_fresh) begin
        m_fresh <= 1'b0;
      end else begin
        m_lfsr <= f_step(m_lfsr);
      end
    end
  end

  task automatic do_reset;
    rstn = 1'b0;
    seed_load = 1'b0;
    seed_in = '0;
    get_random = 1'b0;
    burst_len = '0;
    rnd_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    do_reset();
    n_cmp++;
    if ({rnd_data, rnd_valid, busy, done, state} !== 13'h0) begin
      n_bad++;
      $display("FAIL reset_outs got=%h exp=0",
               {rnd_data, rnd_valid, busy, done, state});
    end
    n_cmp++;
    if (dut.r_lfsr !== SEED) begin
      n_bad++;
      $display("FAIL reset_lfsr got=%h exp=%h", dut.r_lfsr, SEED);
    end
    rstn = 1'b1;
  endtask

  task automatic idle_expect(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      n_cmp++;
      if (rnd_valid !== 1'b0 || done !== 1'b0 || state !== 2'b01) begin
        n_bad++;
        $display("FAIL idle v=%b d=%b st=%b exp 0 0 01",
                 rnd_valid, done, state);
      end
      n_cmp++;
      if (dut.r_lfsr !== m_lfsr) begin
        n_bad++;
        $display("FAIL idle_lfsr got=%h exp=%h", dut.r_lfsr, m_lfsr);
      end
    end
  endtask

  task automatic run_burst(input int len, input int stall_w,
                           input bit rnd_st, input bit noise);
    int s;
    int dn;
    int st;
    logic [7:0] exp;
    dn = 0;
    burst_len = 4'(len);
    get_random = 1'b1;
    @(negedge clk);
    get_random = 1'b0;
    burst_len = 4'($urandom);
    s = hist.size() - 1;
    for (int w = 0; w <= len; w++) begin
      for (int k = 1; k <= OW; k++) begin
        @(negedge clk);
        if (done === 1'b1) dn++;
        if (k < OW) begin
          n_cmp++;
          if (rnd_valid !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL gap w=%0d k=%0d v=%b b=%b exp 0 1",
                     w, k, rnd_valid, busy);
          end
          get_random = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        end
      end
      get_random = 1'b0;
      exp = f_word(s);
      n_cmp++;
      if (rnd_valid !== 1'b1 || rnd_data !== exp) begin
        n_bad++;
        $display("FAIL word w=%0d v=%b data=%h exp 1 %h",
                 w, rnd_valid, rnd_data, exp);
      end
      lfsr_pres = dut.r_lfsr;
      st = (w == stall_w) ? 5 : (rnd_st ? $urandom_range(0, 3) : 0);
      for (int i = 0; i < st; i++) begin
        @(negedge clk);
        n_cmp++;
        if (rnd_valid !== 1'b1 || rnd_data !== exp) begin
          n_bad++;
          $display("FAIL stall_hold v=%b data=%h exp 1 %h",
                   rnd_valid, rnd_data, exp);
        end
      end
      rnd_ready = 1'b1;
      @(negedge clk);
      rnd_ready = 1'b0;
      if (done === 1'b1) dn++;
      n_cmp++;
      if (done !== (w == len) || rnd_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL accept w=%0d done=%b v=%b exp %b 0",
                 w, done, rnd_valid, (w == len));
      end
      s = hist.size() - 1;
      last_word = exp;
    end
    @(negedge clk);
    if (done === 1'b1) dn++;
    n_cmp++;
    if (dn != 1 || state !== 2'b01 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL burst_end dones=%0d st=%b busy=%b exp 1 01 0",
               dn, state, busy);
    end
    n_cmp++;
    if (rnd_data !== last_word) begin
      n_bad++;
      $display("FAIL data_kept got=%h exp=%h", rnd_data, last_word);
    end
  endtask

  task automatic test_first_word;
    run_burst(0, -1, 1'b0, 1'b0);
    n_cmp++;
    if (last_word !== 8'h87) begin
      n_bad++;
      $display("FAIL first_word got=%h exp=87", last_word);
    end
    n_cmp++;
    if (lfsr_pres !== 16'hC2C4) begin
      n_bad++;
      $display("FAIL lfsr_present got=%h exp=c2c4", lfsr_pres);
    end
  endtask

  task automatic test_free_run;
    logic [15:0] seq [4];
    seq = '{16'hACE1, 16'hE270, 16'h7138, 16'h389C};
    do_reset();
    rstn = 1'b1;
    n_cmp++;
    if (dut.r_lfsr !== SEED || state !== 2'b00) begin
      n_bad++;
      $display("FAIL free_start lfsr=%h st=%b exp ace1 00",
               dut.r_lfsr, state);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (dut.r_lfsr !== seq[i] || state !== 2'b01) begin
        n_bad++;
        $display("FAIL free_run i=%0d lfsr=%h st=%b exp %h 01",
                 i, dut.r_lfsr, state, seq[i]);
      end
    end
  endtask

  task automatic test_seed_load;
    get_random = 1'b1;
    burst_len = 4'd2;
    @(negedge clk);
    get_random = 1'b0;
    repeat (3) @(negedge clk);
    seed_load = 1'b1;
    seed_in = 16'h0;
    get_random = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    get_random = 1'b0;
    n_cmp++;
    if (dut.r_lfsr !== 16'hACE1 || state !== 2'b01 ||
        rnd_valid !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL seed_zero lfsr=%h st=%b v=%b d=%b exp ace1 01 0 0",
               dut.r_lfsr, state, rnd_valid, done);
    end
    idle_expect(2 * OW);
    seed_load = 1'b1;
    seed_in = 16'h1234;
    @(negedge clk);
    seed_load = 1'b0;
    n_cmp++;
    if (dut.r_lfsr !== 16'h1234) begin
      n_bad++;
      $display("FAIL seed_1234 got=%h exp=1234", dut.r_lfsr);
    end
    run_burst(1, -1, 1'b1, 1'b0);
  endtask

  task automatic test_busy_ignore;
    run_burst($urandom_range(1, 3), -1, 1'b1, 1'b1);
    idle_expect(2 * OW);
  endtask

  task automatic test_random;
    for (int it = 0; it < 6; it++) begin
      idle_expect($urandom_range(0, 4));
      if ($urandom_range(0, 1) == 1) begin
        seed_load = 1'b1;
        seed_in = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
        @(negedge clk);
        seed_load = 1'b0;
      end
      run_burst($urandom_range(0, 3), -1, 1'b1,
                1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_async_reset;
    get_random = 1'b1;
    burst_len = 4'd3;
    @(negedge clk);
    get_random = 1'b0;
    repeat (OW) @(negedge clk);
    n_cmp++;
    if (rnd_valid !== 1'b1 || state !== 2'b11) begin
      n_bad++;
      $display("FAIL pre_reset v=%b st=%b exp 1 11", rnd_valid, state);
    end
    #2;
    rstn = 1'b0;
    #1;
    n_cmp++;
    if ({rnd_data, rnd_valid, busy, done, state} !== 13'h0 ||
        dut.r_lfsr !== SEED) begin
      n_bad++;
      $display("FAIL async_reset outs=%h lfsr=%h exp 0 ace1",
               {rnd_data, rnd_valid, busy, done, state}, dut.r_lfsr);
    end
    @(negedge clk);
    rstn = 1'b1;
    test_first_word();
  endtask

  initial begin
    rstn = 1'b0;
    test_reset();
    test_first_word();
    test_free_run();
    run_burst(3, 1, 1'b0, 1'b0);
    idle_expect(OW);
    test_seed_load();
    test_busy_ignore();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
